apb_mem_slave_param: RTL and testbench
======================================

Name: apb_mem_slave_param

Overview:
- Parametrised APB (AMBA 3/4 subset) slave fronting a single-port synchronous word memory; next-generation slave for the apb2apb bridge subsystem.
- Adds configurable data/address width, memory depth, programmable wait states, multi-cycle memory read latency, misalignment and read-only-region error detection, and master-abort recovery.
- Sits between the APB fabric and a memory macro or the bridge-side register file.

Parameters:
- ADDR_WIDTH, 32: paddr width in bits.
- DATA_WIDTH, 32: data width in bits; must be 8, 16, 32 or 64.
- MEM_DEPTH, 256: number of words in the memory.
- WAIT_STATES, 0: extra ACCESS cycles inserted on every transfer; range 0..15.
- RD_LATENCY, 1: cycles from the mem_rd pulse to valid mem_rdata; range 1..4.
- RO_BASE, MEM_DEPTH: word index at and above which writes are rejected. The default means no read-only region.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  transfer error; valid only when pready=1.
- mem_wr  out  1  one-cycle memory write pulse.
- mem_rd  out  1  one-cycle memory read pulse.
- mem_be  out  DATA_WIDTH/8  byte enables accompanying mem_wr.
- mem_addr  out  $clog2(MEM_DEPTH)  memory word index.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after mem_rd.

Behaviour:
- Reset: rst=1 on a rising edge forces state IDLE and clears the counter and capture registers. All outputs are 0 from the following cycle. Any pending mem_rd/mem_wr pulse is suppressed. Reset mid-transfer abandons the transfer with no pready.
- Decode:
  - word index = paddr >> log2(DATA_WIDTH/8).
  - err_align = any paddr low byte-offset bit set.
  - err_range = word index >= MEM_DEPTH.
  - err_ro = pwrite and word index >= RO_BASE.
  - err = OR of the three.
- Capture: the setup phase (psel=1, penable=0) is sampled in IDLE. pwrite, word index, pwdata, pstrb and err are registered. The registered values drive every later cycle of the transfer; the bus is not re-sampled.
- States:
  - IDLE: psel & ~penable goes to ACCESS; anything else stays in IDLE. psel & penable with no prior setup is ignored: no pready, no memory access.
  - ACCESS: on entry, if err=0, issue exactly one mem_wr or mem_rd pulse with mem_addr, mem_be=pstrb and mem_wdata. Count cycles.
  - Completion: pready=1 in access cycle N, where access cycle 1 is the first cycle in ACCESS.
    - Write, or any error: N = 1 + WAIT_STATES.
    - Good read: N = 1 + max(WAIT_STATES, RD_LATENCY).
  - After the pready cycle, return to IDLE. The next APB setup phase is accepted in the following cycle, giving back-to-back transfers with no idle gap.
  - Abort: psel=0 while in ACCESS before pready returns to IDLE next cycle. No pready, pslverr stays 0, and an already-issued memory write is not undone.
- Read data: mem_rdata is captured into a register exactly RD_LATENCY cycles after mem_rd. prdata equals that register only in the pready cycle of a good read and is 0 at all other times.
- Error transfers: no memory pulse; pslverr=1 and prdata=0 in the pready cycle.
- Zero-strobe write (pstrb=0, err=0): mem_wr still pulses with mem_be=0, and the transfer completes normally.
- Counter width is $clog2(WAIT_STATES+RD_LATENCY+2); it must not wrap.
- mem_addr, mem_be and mem_wdata are 0 outside the memory pulse cycle.

Test Plan:
Configuration for all scenarios: DATA_WIDTH=32, MEM_DEPTH=256, RD_LATENCY=2, RO_BASE=240.
- WAIT_STATES=0, write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF:
  - mem_wr pulses in access cycle 1 with mem_addr=4, mem_be=0xF.
  - pready=1 in access cycle 1, pslverr=0.
- WAIT_STATES=0, read paddr=0x10, mem_rdata=0xDEADBEEF two cycles after mem_rd:
  - pready in access cycle 3, prdata=0xDEADBEEF.
  - prdata=0 in the cycle before and the cycle after.
- WAIT_STATES=3, read paddr=0x400 (word 256):
  - no mem_rd.
  - pready in access cycle 4, pslverr=1, prdata=0.
- WAIT_STATES=0, write paddr=0x3C4 (word 241) and separately paddr=0x12:
  - both complete with pslverr=1 and no mem_wr.
  - a read of word 241 succeeds.
- Back-to-back: write 0x20 then read 0x20 with no idle cycle:
  - second setup accepted the cycle after the first pready.
  - read returns the written data.
- Abort and reset:
  - psel dropped in access cycle 1 of a WAIT_STATES=3 read: no pready, FSM in IDLE next cycle, the next transfer completes normally.
  - rst asserted mid-write: all outputs 0 the following cycle.

Source files
------------

// File: rtl/apb_mem_slave_param.sv
// APB slave in front of a single-port synchronous word memory.
// Adds programmable wait states, multi-cycle read latency, error decode and abort recovery.
module apb_mem_slave_param #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int RD_LATENCY  = 1,
  parameter int RO_BASE     = MEM_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH/8-1:0]       pstrb,
  output logic                          pready,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pslverr,
  output logic                          mem_wr,
  output logic                          mem_rd,
  output logic [DATA_WIDTH/8-1:0]       mem_be,
  output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int MA_W  = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(WAIT_STATES + RD_LATENCY + 2);
  localparam int N_WR  = 1 + WAIT_STATES;
  localparam int N_RD  = 1 + ((WAIT_STATES > RD_LATENCY) ? WAIT_STATES : RD_LATENCY);
  localparam int N_CAP = 1 + RD_LATENCY;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ROB_A    = ADDR_WIDTH'(RO_BASE);
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, err_q;
  logic [MA_W-1:0]       addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [NB-1:0]         strb_q;

  logic [ADDR_WIDTH-1:0] widx;
  logic                  err_dec, setup, done, pulse, good_rd, cap;
  logic [CNT_W-1:0]      n_done;

  assign widx    = paddr >> OFF_W;
  assign err_dec = (|(paddr & OFF_MASK)) | (widx >= DEPTH_A) | (pwrite & (widx >= ROB_A));
  assign setup   = psel & ~penable;
  assign n_done  = (wr_q | err_q) ? CNT_W'(N_WR) : CNT_W'(N_RD);
  assign done    = (cnt_q == n_done);
  assign pulse   = (state_q == S_ACCESS) && (cnt_q == CNT_W'(1)) && !err_q;
  assign good_rd = !wr_q && !err_q;
  // Read data is valid on the bus exactly RD_LATENCY cycles after the mem_rd pulse.
  assign cap     = (state_q == S_ACCESS) && good_rd && (cnt_q == CNT_W'(N_CAP));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_W'(1);
        end
      end
      S_ACCESS: begin
        if (!psel || done) state_d = S_IDLE;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer attributes are frozen at the setup phase; the bus is not re-sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == S_IDLE && setup) begin
        wr_q    <= pwrite;
        err_q   <= err_dec;
        addr_q  <= widx[MA_W-1:0];
        wdata_q <= pwdata;
        strb_q  <= pstrb;
      end
      if (cap) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_ACCESS) begin
      pready  = psel && done;
      pslverr = pready && err_q;
      // When the pready cycle coincides with the capture cycle, forward the bus value.
      if (pready && good_rd) prdata = cap ? mem_rdata : rdata_q;
      if (pulse) begin
        mem_wr   = wr_q;
        mem_rd   = !wr_q;
        mem_addr = addr_q;
        if (wr_q) begin
          mem_be    = strb_q;
          mem_wdata = wdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Bench for apb_mem_slave_param: two instances (0 and 3 wait states) with a
// two-cycle-latency memory model each, directed steps followed by random transfers.
module tb_apb_mem_slave_param;

  localparam int RL  = 2;
  localparam int ROB = 240;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb [2];
  logic        pready [2];
  logic [31:0] prdata [2];
  logic        pslverr [2];
  logic        mem_wr [2];
  logic        mem_rd [2];
  logic [3:0]  mem_be [2];
  logic [7:0]  mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] ref_mem [2][256];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] macro [256];
    logic        p1v, p2v;
    logic [7:0]  p1a, p2a;
    logic [31:0] junk;

    apb_mem_slave_param #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
      .WAIT_STATES(g * 3), .RD_LATENCY(RL), .RO_BASE(ROB)
    ) u_dut (
      .clk(clk), .rst(rst),
      .psel(psel[g]), .penable(penable[g]), .pwrite(pwrite[g]),
      .paddr(paddr[g]), .pwdata(pwdata[g]), .pstrb(pstrb[g]),
      .pready(pready[g]), .prdata(prdata[g]), .pslverr(pslverr[g]),
      .mem_wr(mem_wr[g]), .mem_rd(mem_rd[g]), .mem_be(mem_be[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) macro[i] = init_val(i);
      p1v = 1'b0; p2v = 1'b0; p1a = '0; p2a = '0; junk = 32'h0BAD_0BAD;
    end

    // Memory macro: byte-enabled writes, reads return data two cycles after mem_rd.
    always @(posedge clk) begin
      if (mem_wr[g])
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) macro[mem_addr[g]][b*8 +: 8] <= mem_wdata[g][b*8 +: 8];
      p1v  <= mem_rd[g];
      p1a  <= mem_addr[g];
      p2v  <= p1v;
      p2a  <= p1a;
      junk <= $urandom;
    end
    assign mem_rdata[g] = p2v ? macro[p2a] : junk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(input int d, input string tag);
    chk({tag, "_pready"}, pready[d], 0);
    chk({tag, "_pslverr"}, pslverr[d], 0);
    chk({tag, "_prdata"}, prdata[d], 0);
    chk({tag, "_mem_wr"}, mem_wr[d], 0);
    chk({tag, "_mem_rd"}, mem_rd[d], 0);
    chk({tag, "_mem_be"}, mem_be[d], 0);
    chk({tag, "_mem_addr"}, mem_addr[d], 0);
    chk({tag, "_mem_wdata"}, mem_wdata[d], 0);
  endtask

  task automatic idle();
    tick();
    for (int e = 0; e < 2; e++) begin psel[e] = 1'b0; penable[e] = 1'b0; end
    #1;
    zeros(0, "idle0");
    zeros(1, "idle1");
  endtask

  // One complete APB transfer, ending in its pready cycle so a following call is back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] idx, exp_rd, upd;
    bit          err, pul;
    int          ws, n_exp;
    bit          done;
    idx   = addr >> 2;
    err   = (addr[1:0] != 2'b00) || (idx >= 256) || (wr && idx >= ROB);
    ws    = d * 3;
    n_exp = (wr || err) ? 1 + ws : 1 + ((ws > RL) ? ws : RL);
    exp_rd = (!wr && !err) ? ref_mem[d][idx[7:0]] : 32'h0;

    tick();
    for (int e = 0; e < 2; e++) if (e != d) begin psel[e] = 1'b0; penable[e] = 1'b0; end
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    #1;
    chk("setup_pready", pready[d], 0);
    chk("setup_prdata", prdata[d], 0);

    tick();
    penable[d] = 1'b1;
    done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      if (k > 1) tick();
      #1;
      pul = (k == 1) && !err;
      chk("mem_wr", mem_wr[d], pul && wr);
      chk("mem_rd", mem_rd[d], pul && !wr);
      chk("mem_addr", mem_addr[d], pul ? {24'h0, idx[7:0]} : 32'h0);
      chk("mem_be", mem_be[d], (pul && wr) ? strb : 4'h0);
      chk("mem_wdata", mem_wdata[d], (pul && wr) ? wdata : 32'h0);
      if (k < n_exp) begin
        chk("early_pready", pready[d], 0);
        chk("early_prdata", prdata[d], 0);
      end else begin
        chk("pready", pready[d], 1);
        chk("pslverr", pslverr[d], err);
        chk("prdata", prdata[d], exp_rd);
        done = 1'b1;
      end
    end
    if (!done) chk("pready_timeout", 0, 1);

    if (wr && !err) begin
      upd = ref_mem[d][idx[7:0]];
      for (int b = 0; b < 4; b++) if (strb[b]) upd[b*8 +: 8] = wdata[b*8 +: 8];
      ref_mem[d][idx[7:0]] = upd;
    end
  endtask

  initial begin
    logic [31:0] a, idx;
    int          r, d;
    bit          wr;

    for (int e = 0; e < 2; e++) begin
      psel[e] = 1'b0; penable[e] = 1'b0; pwrite[e] = 1'b0;
      paddr[e] = '0; pwdata[e] = '0; pstrb[e] = '0;
      for (int i = 0; i < 256; i++) ref_mem[e][i] = init_val(i);
    end

    rst = 1'b1;
    repeat (3) tick();
    zeros(0, "reset0");
    zeros(1, "reset1");
    rst = 1'b0;
    idle();

    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    idle();
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    idle();
    xfer(1, 1'b0, 32'h400, 32'h0, 4'h0);
    idle();
    xfer(0, 1'b1, 32'h3C4, 32'h1234_5678, 4'hF);
    xfer(0, 1'b1, 32'h12, 32'h1234_5678, 4'hF);
    xfer(0, 1'b0, 32'h3C4, 32'h0, 4'h0);
    xfer(0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0);
    xfer(1, 1'b1, 32'h24, 32'hA1B2_C3D4, 4'h5);
    xfer(1, 1'b0, 32'h24, 32'h0, 4'h0);
    xfer(1, 1'b1, 32'h28, 32'hFFFF_FFFF, 4'h0);
    xfer(1, 1'b0, 32'h28, 32'h0, 4'h0);
    idle();

    // Abort: psel dropped in access cycle 1 of a 3-wait-state read.
    tick();
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h14;
    tick();
    psel[1] = 1'b0; penable[1] = 1'b1;
    #1;
    chk("abort_pready", pready[1], 0);
    chk("abort_pslverr", pslverr[1], 0);
    tick();
    psel[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      zeros(1, "post_abort");
      tick();
    end
    xfer(1, 1'b0, 32'h14, 32'h0, 4'h0);
    idle();

    // Reset in the middle of a 3-wait-state write.
    tick();
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h80; pwdata[1] = 32'h7777_7777; pstrb[1] = 4'hF;
    tick();
    penable[1] = 1'b1;
    #1;
    chk("rst_mid_mem_wr", mem_wr[1], 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_pready", pready[1], 0);
    tick();
    rst = 1'b0;
    #1;
    zeros(1, "after_rst1");
    zeros(0, "after_rst0");
    tick();
    #1;
    zeros(1, "after_rst_idle");
    idle();

    for (int t = 0; t < 60; t++) begin
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 7)       idx = $urandom_range(0, 31);
      else if (r == 7) idx = $urandom_range(240, 255);
      else             idx = $urandom_range(256, 300);
      a = idx << 2;
      if (r == 9) a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
